// File: rtl/gpio_conv_ctrl.sv
// Host command sequencer between the GPIO word pair and the 2D convolution datapath.
// Decodes toggle-handshaked commands, loads kernel/pixels, runs the convolution and returns results.
module gpio_conv_ctrl #(
    parameter int BIT_LEN    = 8,
    parameter int CONV_LEN   = 20,
    parameter int M_LEN      = 3,
    parameter int NB_ADDRESS = 10,
    parameter int RAM_WIDTH  = 13,
    parameter int GPIO_D     = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic [GPIO_D-1:0]     i_gpio,
    output logic [GPIO_D-1:0]     o_gpio,
    output logic                  o_k_we,
    output logic [3:0]            o_k_idx,
    output logic [BIT_LEN-1:0]    o_k_data,
    output logic                  o_ram_we,
    output logic [NB_ADDRESS-1:0] o_ram_addr,
    output logic [RAM_WIDTH-1:0]  o_ram_data,
    output logic [NB_ADDRESS-1:0] o_img_width,
    output logic                  o_conv_start,
    input  logic                  i_conv_done,
    input  logic [CONV_LEN-1:0]   i_conv_data,
    output logic                  o_led
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_RD_WAIT = 2'd3;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_SOFT_RST = 4'd1;
    localparam logic [3:0] OP_LOAD_K   = 4'd2;
    localparam logic [3:0] OP_LOAD_PIX = 4'd3;
    localparam logic [3:0] OP_SET_SIZE = 4'd4;
    localparam logic [3:0] OP_START    = 4'd5;
    localparam logic [3:0] OP_READ     = 4'd6;

    localparam logic [3:0]            K_LAST  = 4'(M_LEN * M_LEN - 1);
    localparam logic [NB_ADDRESS-1:0] MIN_WID = NB_ADDRESS'(M_LEN);

    logic [3:0]            gpio_op_reg;
    logic                  gpio_tog_reg;
    logic [RAM_WIDTH-1:0]  gpio_pay_reg;

    logic [1:0]            state_reg;
    logic                  last_tog_reg;
    logic [3:0]            op_reg;
    logic [RAM_WIDTH-1:0]  payload_reg;
    logic [3:0]            k_cnt_reg;
    logic [NB_ADDRESS-1:0] a_cnt_reg;
    logic                  ack_tog_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic [CONV_LEN-1:0]   result_reg;
    logic                  k_we_reg;
    logic [3:0]            k_idx_reg;
    logic [BIT_LEN-1:0]    k_data_reg;
    logic                  ram_we_reg;
    logic [NB_ADDRESS-1:0] ram_addr_reg;
    logic [RAM_WIDTH-1:0]  ram_data_reg;
    logic [NB_ADDRESS-1:0] img_width_reg;
    logic                  conv_start_reg;

    logic busy;
    logic accept;
    logic clear_all;
    logic unused_rsvd;

    assign busy        = (state_reg != ST_IDLE);
    assign accept      = !busy && (gpio_tog_reg != last_tog_reg);
    assign clear_all   = i_reset || (state_reg == ST_EXEC && op_reg == OP_SOFT_RST);
    assign unused_rsvd = ^i_gpio[26:RAM_WIDTH];

    // Pin sampling is kept outside the soft reset so a held toggle is not re-seen as new.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            gpio_op_reg  <= '0;
            gpio_tog_reg <= 1'b0;
            gpio_pay_reg <= '0;
        end else begin
            gpio_op_reg  <= i_gpio[31:28];
            gpio_tog_reg <= i_gpio[27];
            gpio_pay_reg <= i_gpio[RAM_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_CLK) begin
        if (clear_all) begin
            state_reg      <= ST_IDLE;
            last_tog_reg   <= i_reset ? 1'b0 : last_tog_reg;
            ack_tog_reg    <= i_reset ? 1'b0 : last_tog_reg;
            op_reg         <= '0;
            payload_reg    <= '0;
            k_cnt_reg      <= '0;
            a_cnt_reg      <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            result_reg     <= '0;
            k_we_reg       <= 1'b0;
            k_idx_reg      <= '0;
            k_data_reg     <= '0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_data_reg   <= '0;
            img_width_reg  <= '0;
            conv_start_reg <= 1'b0;
        end else begin
            k_we_reg       <= 1'b0;
            ram_we_reg     <= 1'b0;
            conv_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        last_tog_reg <= gpio_tog_reg;
                        op_reg       <= gpio_op_reg;
                        payload_reg  <= gpio_pay_reg;
                        state_reg    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    ack_tog_reg <= last_tog_reg;
                    state_reg   <= ST_IDLE;
                    case (op_reg)
                        OP_NOP: ;
                        OP_LOAD_K: begin
                            k_we_reg   <= 1'b1;
                            k_idx_reg  <= k_cnt_reg;
                            k_data_reg <= payload_reg[BIT_LEN-1:0];
                            k_cnt_reg  <= (k_cnt_reg == K_LAST) ? 4'd0 : k_cnt_reg + 4'd1;
                        end
                        OP_LOAD_PIX: begin
                            ram_we_reg   <= 1'b1;
                            ram_addr_reg <= a_cnt_reg;
                            ram_data_reg <= payload_reg;
                            a_cnt_reg    <= a_cnt_reg + 1'b1;
                        end
                        OP_SET_SIZE: begin
                            img_width_reg <= payload_reg[NB_ADDRESS-1:0];
                            a_cnt_reg     <= '0;
                            k_cnt_reg     <= '0;
                        end
                        OP_START: begin
                            if (img_width_reg < MIN_WID) begin
                                err_reg <= 1'b1;
                            end else begin
                                // Ack is deferred until the datapath reports completion.
                                ack_tog_reg    <= ack_tog_reg;
                                err_reg        <= 1'b0;
                                done_reg       <= 1'b0;
                                conv_start_reg <= 1'b1;
                                state_reg      <= ST_RUN;
                            end
                        end
                        OP_READ: begin
                            ack_tog_reg  <= ack_tog_reg;
                            ram_addr_reg <= payload_reg[NB_ADDRESS-1:0];
                            state_reg    <= ST_RD_WAIT;
                        end
                        default: err_reg <= 1'b1;
                    endcase
                end
                ST_RUN: begin
                    if (i_conv_done) begin
                        done_reg    <= 1'b1;
                        ack_tog_reg <= last_tog_reg;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: begin
                    result_reg  <= i_conv_data;
                    ack_tog_reg <= last_tog_reg;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gpio       = {ack_tog_reg, busy, done_reg, err_reg,
                           {(GPIO_D - 4 - CONV_LEN){unused_rsvd & 1'b0}}, result_reg};
    assign o_k_we       = k_we_reg;
    assign o_k_idx      = k_idx_reg;
    assign o_k_data     = k_data_reg;
    assign o_ram_we     = ram_we_reg;
    assign o_ram_addr   = ram_addr_reg;
    assign o_ram_data   = ram_data_reg;
    assign o_img_width  = img_width_reg;
    assign o_conv_start = conv_start_reg;
    assign o_led        = busy;

endmodule

// File: tb/tb_gpio_conv_ctrl.sv
// Directed bench for gpio_conv_ctrl: table of single commands plus hand sequences for run/read/reset.
module tb_gpio_conv_ctrl;

    logic        clk;
    logic        i_reset;
    logic [31:0] i_gpio;
    logic [31:0] o_gpio;
    logic        o_k_we;
    logic [3:0]  o_k_idx;
    logic [7:0]  o_k_data;
    logic        o_ram_we;
    logic [9:0]  o_ram_addr;
    logic [12:0] o_ram_data;
    logic [9:0]  o_img_width;
    logic        o_conv_start;
    logic        i_conv_done;
    logic [19:0] i_conv_data;
    logic        o_led;

    gpio_conv_ctrl dut (
        .i_CLK(clk), .i_reset(i_reset), .i_gpio(i_gpio), .o_gpio(o_gpio),
        .o_k_we(o_k_we), .o_k_idx(o_k_idx), .o_k_data(o_k_data),
        .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
        .o_img_width(o_img_width), .o_conv_start(o_conv_start),
        .i_conv_done(i_conv_done), .i_conv_data(i_conv_data), .o_led(o_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic tog = 1'b0;

    int k_writes = 0, ram_writes = 0, starts = 0;
    logic [3:0]  last_k_idx;
    logic [7:0]  last_k_data;
    logic [9:0]  last_ram_addr;
    logic [12:0] last_ram_data;

    always @(posedge clk) begin
        if (o_k_we === 1'b1) begin
            k_writes++; last_k_idx = o_k_idx; last_k_data = o_k_data;
        end
        if (o_ram_we === 1'b1) begin
            ram_writes++; last_ram_addr = o_ram_addr; last_ram_data = o_ram_data;
        end
        if (o_conv_start === 1'b1) starts++;
    end

    typedef struct {
        logic [3:0]  op;
        logic [12:0] pay;
        int          kind;   // 0 ack only, 1 kernel write, 2 ram write, 3 width
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, got);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [12:0] pay);
        tog = ~tog;
        i_gpio = {op, tog, 14'b0, pay};
    endtask

    task automatic wait_ack(input string name, input logic val, input int budget);
        int n = 0;
        while (o_gpio[31] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " ack_tog"}, {31'b0, o_gpio[31]}, {31'b0, val});
    endtask

    task automatic cmd(input string name, input logic [3:0] op, input logic [12:0] pay);
        @(negedge clk);
        issue(op, pay);
        wait_ack(name, tog, 20);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [12:0] pay, input int kind,
                                input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.op = op; v.pay = pay; v.kind = kind; v.exp_a = a; v.exp_b = b;
        return v;
    endfunction

    initial begin
        int kw0, rw0, s0;
        logic t0, t1, t2;

        i_reset = 1'b1; i_gpio = '0; i_conv_done = 1'b0; i_conv_data = '0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check("reset o_gpio", o_gpio, 32'h0);
        check("reset o_led", {31'b0, o_led}, 32'h0);
        check("reset strobes", k_writes + ram_writes + starts, 0);

        vecs.push_back(mk(4'd4, 13'd8, 3, 32'd8, 0));
        for (int i = 0; i < 9; i++) vecs.push_back(mk(4'd2, 13'(i + 1), 1, i, i + 1));
        vecs.push_back(mk(4'd2, 13'h55, 1, 0, 32'h55));
        vecs.push_back(mk(4'd2, 13'h66, 1, 1, 32'h66));
        vecs.push_back(mk(4'd4, 13'd16, 3, 32'd16, 0));
        vecs.push_back(mk(4'd3, 13'h100, 2, 0, 32'h100));
        vecs.push_back(mk(4'd3, 13'h200, 2, 1, 32'h200));
        vecs.push_back(mk(4'd3, 13'h300, 2, 2, 32'h300));
        vecs.push_back(mk(4'd2, 13'h77, 1, 0, 32'h77));
        vecs.push_back(mk(4'd0, 13'h0, 0, 0, 0));

        foreach (vecs[i]) begin
            kw0 = k_writes; rw0 = ram_writes;
            cmd($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].op, vecs[i].pay);
            case (vecs[i].kind)
                1: begin
                    check($sformatf("vec%0d k_idx", i), {28'b0, last_k_idx}, vecs[i].exp_a);
                    check($sformatf("vec%0d k_data", i), {24'b0, last_k_data}, vecs[i].exp_b);
                    check($sformatf("vec%0d k_we count", i), k_writes - kw0, 1);
                end
                2: begin
                    check($sformatf("vec%0d ram_addr", i), {22'b0, last_ram_addr}, vecs[i].exp_a);
                    check($sformatf("vec%0d ram_data", i), {19'b0, last_ram_data}, vecs[i].exp_b);
                    check($sformatf("vec%0d ram_we count", i), ram_writes - rw0, 1);
                end
                3: check($sformatf("vec%0d img_width", i), {22'b0, o_img_width}, vecs[i].exp_a);
                default: check($sformatf("vec%0d no strobe", i), (k_writes - kw0) + (ram_writes - rw0), 0);
            endcase
        end

        // START held off by the datapath; a NOP issued meanwhile must wait for completion.
        s0 = starts;
        t0 = tog;
        @(negedge clk);
        issue(4'd5, 13'd0);
        t1 = tog;
        repeat (50) @(negedge clk);
        check("run busy/done", {30'b0, o_gpio[30:29]}, 32'b10);
        check("run led", {31'b0, o_led}, 32'd1);
        check("run start pulses", starts - s0, 1);
        issue(4'd0, 13'd0);
        t2 = tog;
        repeat (10) @(negedge clk);
        check("held nop ack/busy", {30'b0, o_gpio[31:30]}, {30'b0, t0, 1'b1});
        i_conv_done = 1'b1;
        wait_ack("start", t1, 10);
        i_conv_done = 1'b0;
        check("start done", {31'b0, o_gpio[29]}, 32'd1);
        wait_ack("held nop", t2, 20);
        check("nop after run done/err", {30'b0, o_gpio[29:28]}, 32'b10);
        check("single start pulse", starts - s0, 1);

        cmd("op9", 4'd9, 13'd0);
        check("op9 err", {31'b0, o_gpio[28]}, 32'd1);

        cmd("soft_rst", 4'd1, 13'd0);
        check("soft_rst done/err", {30'b0, o_gpio[29:28]}, 32'b0);
        check("soft_rst width", {22'b0, o_img_width}, 32'd0);
        kw0 = k_writes;
        cmd("load_k after soft_rst", 4'd2, 13'h12);
        check("soft_rst k_idx", {28'b0, last_k_idx}, 32'd0);

        @(negedge clk);
        i_conv_done = 1'b1;
        repeat (3) @(negedge clk);
        i_conv_done = 1'b0;
        check("idle done ignored", {30'b0, o_gpio[30:29]}, 32'b0);

        s0 = starts;
        cmd("set_size 2", 4'd4, 13'd2);
        cmd("short start", 4'd5, 13'd0);
        repeat (3) @(negedge clk);
        check("short start err/busy", {29'b0, o_gpio[30:28]}, 32'b001);
        check("short start no pulse", starts - s0, 0);

        cmd("set_size 16b", 4'd4, 13'd16);
        i_conv_data = 20'hABCDE;
        cmd("read 5", 4'd6, 13'd5);
        check("read result", {12'b0, o_gpio[19:0]}, 32'hABCDE);
        check("read addr", {22'b0, o_ram_addr}, 32'd5);

        @(negedge clk);
        issue(4'd5, 13'd0);
        repeat (6) @(negedge clk);
        check("pre-reset busy", {31'b0, o_gpio[30]}, 32'd1);
        i_reset = 1'b1;
        i_gpio = '0;
        tog = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        check("abort o_gpio", o_gpio, 32'h0);
        check("abort led", {31'b0, o_led}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort stays idle", {31'b0, o_led}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
